// File: rtl/timer_pkg.sv
// Shared encodings for the timer/counter bank: modes, register fields and CTRL layout.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  localparam logic [1:0] F_TL   = 2'd0;
  localparam logic [1:0] F_TH   = 2'd1;
  localparam logic [1:0] F_CTRL = 2'd2;
  localparam logic [1:0] F_FLAG = 2'd3;

  localparam int unsigned CTRL_MODE_LSB = 0;
  localparam int unsigned CTRL_CT       = 2;
  localparam int unsigned CTRL_GATE     = 3;
  localparam int unsigned CTRL_TR       = 4;

  // Packed so that the struct matches the CTRL byte bits 4:0 directly.
  typedef struct packed {
    logic  tr;
    logic  gate;
    logic  ct;
    mode_e mode;
  } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One timer/counter channel: input synchronisers, edge detect, mode logic and overflow flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             t_pin,
  input  logic             int_pin,
  input  logic             we_tl,
  input  logic             we_th,
  input  logic             we_ctrl,
  input  logic             we_flag,
  input  logic [7:0]       wdata,
  input  logic             tf_clr,
  output logic [7:0]       tl,
  output logic [WIDTH-9:0] th,
  output ctrl_t            ctrl,
  output logic             tf
);

  logic [2:0]       t_sync_q;
  logic [1:0]       int_sync_q;
  logic [7:0]       tl_q, tl_d;
  logic [WIDTH-9:0] th_q, th_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             tf_q, tf_d;
  logic             fall, run, inc, ovf;
  logic [WIDTH-1:0] count, count_inc;

  // Stage 2 is the synchronised level; stage 3 only serves the falling-edge compare.
  assign fall      = t_sync_q[2] & ~t_sync_q[1];
  assign run       = ctrl_q.tr & (~ctrl_q.gate | int_sync_q[1]);
  assign inc       = run & (ctrl_q.ct ? fall : tick);
  assign count     = {th_q, tl_q};
  assign count_inc = count + WIDTH'(1);

  always_comb begin
    tl_d   = tl_q;
    th_d   = th_q;
    ctrl_d = ctrl_q;
    tf_d   = tf_q;
    ovf    = 1'b0;
    // A register write in the same cycle swallows that cycle's increment.
    if (we_tl || we_th || we_ctrl) begin
      if (we_tl)   tl_d   = wdata;
      if (we_th)   th_d   = wdata[WIDTH-9:0];
      if (we_ctrl) ctrl_d = ctrl_t'(wdata[4:0]);
    end else if (inc) begin
      unique case (ctrl_q.mode)
        MODE_FREE, MODE_ONESHOT: begin
          {th_d, tl_d} = count_inc;
          ovf          = &count;
          if (ovf && ctrl_q.mode == MODE_ONESHOT) ctrl_d.tr = 1'b0;
        end
        MODE_RELOAD: begin
          if (&tl_q) begin
            tl_d = 8'(th_q);
            ovf  = 1'b1;
          end else begin
            tl_d = tl_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    if (we_flag)     tf_d = wdata[0];
    else if (ovf)    tf_d = 1'b1;
    else if (tf_clr) tf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_sync_q   <= '0;
      int_sync_q <= '0;
      tl_q       <= '0;
      th_q       <= '0;
      ctrl_q     <= '0;
      tf_q       <= 1'b0;
    end else begin
      t_sync_q   <= {t_sync_q[1:0], t_pin};
      int_sync_q <= {int_sync_q[0], int_pin};
      tl_q       <= tl_d;
      th_q       <= th_d;
      ctrl_q     <= ctrl_d;
      tf_q       <= tf_d;
    end
  end

  assign tl   = tl_q;
  assign th   = th_q;
  assign ctrl = ctrl_q;
  assign tf   = tf_q;

endmodule

// File: rtl/timer_counter_bank.sv
// Bank of 8051-style timer/counters: shared machine-cycle prescaler, register decode, read mux.
module timer_counter_bank
  import timer_pkg::*;
#(
  parameter int unsigned NUM_TIMERS = 2,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE   = 12,
  localparam int unsigned AW        = $clog2(NUM_TIMERS) + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TIMERS-1:0] t_pin,
  input  logic [NUM_TIMERS-1:0] int_pin,
  input  logic                  reg_we,
  input  logic [AW-1:0]         reg_addr,
  input  logic [7:0]            reg_wdata,
  output logic [7:0]            reg_rdata,
  input  logic [NUM_TIMERS-1:0] tf_clr,
  output logic [NUM_TIMERS-1:0] tf,
  output logic [NUM_TIMERS-1:0] tr
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [AW-1:0]    ch_sel;
  logic [1:0]       field;
  logic [7:0]       tl_arr   [NUM_TIMERS];
  logic [WIDTH-9:0] th_arr   [NUM_TIMERS];
  ctrl_t            ctrl_arr [NUM_TIMERS];

  assign tick  = (pre_q == PW'(PRESCALE - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  assign ch_sel = reg_addr >> 2;
  assign field  = reg_addr[1:0];

  // Channel indices past NUM_TIMERS match no instance, so they ignore writes and read 0.
  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    logic sel;
    assign sel = reg_we && (ch_sel == AW'(g));

    timer_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .t_pin   (t_pin[g]),
      .int_pin (int_pin[g]),
      .we_tl   (sel && field == F_TL),
      .we_th   (sel && field == F_TH),
      .we_ctrl (sel && field == F_CTRL),
      .we_flag (sel && field == F_FLAG),
      .wdata   (reg_wdata),
      .tf_clr  (tf_clr[g]),
      .tl      (tl_arr[g]),
      .th      (th_arr[g]),
      .ctrl    (ctrl_arr[g]),
      .tf      (tf[g])
    );

    assign tr[g] = ctrl_arr[g].tr;
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (ch_sel == AW'(i)) begin
        unique case (field)
          F_TL:    reg_rdata = tl_arr[i];
          F_TH:    reg_rdata = 8'(th_arr[i]);
          F_CTRL:  reg_rdata = {3'b000, ctrl_arr[i]};
          default: reg_rdata = {7'b0, tf[i]};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_counter_bank.sv
// Bench for timer_counter_bank: directed scenarios plus random traffic against a behavioural model.
module tb_timer_counter_bank;

  localparam int NT = 3;
  localparam int W  = 16;
  localparam int P  = 12;
  localparam int AW = $clog2(NT) + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NT-1:0] t_pin, int_pin, tf_clr, tf, tr;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata, reg_rdata;

  int checks = 0;
  int errors = 0;

  // Model state: plain integers per channel, sample histories for the pin inputs.
  int m_pre;
  int m_tl[NT], m_th[NT], m_mode[NT], m_ct[NT], m_gate[NT], m_tr[NT], m_tf[NT];
  int t_hist[NT][3], i_hist[NT][3];

  timer_counter_bank #(
    .NUM_TIMERS (NT),
    .WIDTH      (W),
    .PRESCALE   (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .t_pin     (t_pin),
    .int_pin   (int_pin),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .tf_clr    (tf_clr),
    .tf        (tf),
    .tr        (tr)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_read(input int a);
    int ch, f;
    ch = a / 4;
    f  = a % 4;
    if (ch >= NT) return 0;
    case (f)
      0:       return m_tl[ch];
      1:       return m_th[ch];
      2:       return m_mode[ch] + 4 * m_ct[ch] + 8 * m_gate[ch] + 16 * m_tr[ch];
      default: return m_tf[ch];
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int  ch, f, cnt;
    bit  tick, fall, isync, run, ev, wr, ovf;
    if (reset) begin
      m_pre = 0;
      for (int i = 0; i < NT; i++) begin
        m_tl[i] = 0; m_th[i] = 0; m_mode[i] = 0; m_ct[i] = 0;
        m_gate[i] = 0; m_tr[i] = 0; m_tf[i] = 0;
        for (int k = 0; k < 3; k++) begin
          t_hist[i][k] = 0;
          i_hist[i][k] = 0;
        end
      end
      return;
    end
    tick  = (m_pre == P - 1);
    m_pre = (m_pre + 1) % P;
    ch    = int'(reg_addr) / 4;
    f     = int'(reg_addr) % 4;
    for (int i = 0; i < NT; i++) begin
      // hist[0] is the previous edge's sample, hist[2] three edges back.
      fall  = (t_hist[i][2] == 1) && (t_hist[i][1] == 0);
      isync = (i_hist[i][1] == 1);
      run   = (m_tr[i] == 1) && (m_gate[i] == 0 || isync);
      ev    = run && ((m_ct[i] == 1) ? fall : tick);
      wr    = reg_we && (ch == i);
      ovf   = 0;
      if (wr && f < 3) begin
        if (f == 0) m_tl[i] = reg_wdata;
        if (f == 1) m_th[i] = reg_wdata % (1 << (W - 8));
        if (f == 2) begin
          m_mode[i] = reg_wdata % 4;
          m_ct[i]   = (reg_wdata / 4) % 2;
          m_gate[i] = (reg_wdata / 8) % 2;
          m_tr[i]   = (reg_wdata / 16) % 2;
        end
      end else if (ev) begin
        if (m_mode[i] == 0 || m_mode[i] == 2) begin
          cnt = m_th[i] * 256 + m_tl[i] + 1;
          if (cnt == (1 << W)) begin
            cnt = 0;
            ovf = 1;
            if (m_mode[i] == 2) m_tr[i] = 0;
          end
          m_tl[i] = cnt % 256;
          m_th[i] = cnt / 256;
        end else if (m_mode[i] == 1) begin
          if (m_tl[i] == 255) begin
            m_tl[i] = m_th[i] % 256;
            ovf = 1;
          end else begin
            m_tl[i] = m_tl[i] + 1;
          end
        end
      end
      if (wr && f == 3)   m_tf[i] = reg_wdata % 2;
      else if (ovf)       m_tf[i] = 1;
      else if (tf_clr[i]) m_tf[i] = 0;
      t_hist[i][2] = t_hist[i][1]; t_hist[i][1] = t_hist[i][0]; t_hist[i][0] = int'(t_pin[i]);
      i_hist[i][2] = i_hist[i][1]; i_hist[i][1] = i_hist[i][0]; i_hist[i][0] = int'(int_pin[i]);
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] keep;
    keep = reg_addr;
    for (int a = 0; a < (1 << AW); a++) begin
      reg_addr = AW'(a);
      #1;
      check($sformatf("rd[%0d]", a), reg_rdata, model_read(a));
    end
    for (int i = 0; i < NT; i++) begin
      check($sformatf("tf[%0d]", i), tf[i], m_tf[i]);
      check($sformatf("tr[%0d]", i), tr[i], m_tr[i]);
    end
    reg_addr = keep;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    reg_we    = 1'b1;
    reg_addr  = AW'(addr);
    reg_wdata = data;
    cycle();
    reg_we    = 1'b0;
  endtask

  task automatic expect_lit(input string name, input int addr, input logic [7:0] val);
    reg_addr = AW'(addr);
    #1;
    check(name, reg_rdata, val);
    check({name, "_model"}, model_read(addr), val);
  endtask

  task automatic expect_bit(input string name, input logic act, input int mdl, input logic val);
    check(name, act, val);
    check({name, "_model"}, mdl, val);
  endtask

  task automatic wait_tick_next();
    int k = 0;
    while (m_pre != P - 1 && k < 2 * P) begin
      cycle();
      k++;
    end
    check("tick_align", (k < 2 * P), 1);
  endtask

  initial begin
    reset = 1'b1; t_pin = '0; int_pin = '0; tf_clr = '0;
    reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    repeat (3) cycle();
    reset = 1'b0;
    t_pin = '1;
    expect_lit("rst_tl0", 0, 8'h00);
    expect_lit("rst_ctrl1", 6, 8'h00);
    expect_bit("rst_tf0", tf[0], m_tf[0], 1'b0);

    // Mode 0 timer overflow on ch0.
    wr(0, 8'hFE); wr(1, 8'hFF); wr(2, 8'h10);
    repeat (12) cycle();
    expect_lit("m0_tl_ff", 0, 8'hFF);
    expect_lit("m0_th_ff", 1, 8'hFF);
    repeat (12) cycle();
    expect_lit("m0_tl_00", 0, 8'h00);
    expect_lit("m0_th_00", 1, 8'h00);
    expect_bit("m0_tf0", tf[0], m_tf[0], 1'b1);
    expect_bit("m0_tf1", tf[1], m_tf[1], 1'b0);

    // Mode 1 auto-reload on ch1, then acknowledge.
    wr(5, 8'hFC); wr(4, 8'hFC); wr(6, 8'h11);
    repeat (48) cycle();
    expect_lit("m1_tl", 4, 8'hFC);
    expect_lit("m1_th", 5, 8'hFC);
    expect_bit("m1_tf1", tf[1], m_tf[1], 1'b1);
    tf_clr = 3'b010;
    cycle();
    tf_clr = '0;
    expect_lit("m1_flag_clr", 7, 8'h00);
    wr(2, 8'h00); wr(6, 8'h00);
    wr(0, 8'h00); wr(1, 8'h00); wr(4, 8'h00); wr(5, 8'h00);

    // Counter mode on ch1: falling edges, 4-clk phases.
    wr(6, 8'h14);
    for (int n = 0; n < 3; n++) begin
      t_pin[1] = 1'b0;
      repeat (2) cycle();
      expect_lit($sformatf("cnt_pre%0d", n), 4, 8'(n));
      cycle();
      expect_lit($sformatf("cnt_post%0d", n), 4, 8'(n + 1));
      cycle();
      t_pin[1] = 1'b1;
      repeat (4) cycle();
    end
    expect_lit("cnt_tl3", 4, 8'h03);
    expect_lit("cnt_ch0", 0, 8'h00);
    wr(6, 8'h00);

    // Gate: held off while int_pin low, two ticks once enabled.
    wr(2, 8'h18);
    repeat (50) cycle();
    expect_lit("gate_hold", 0, 8'h00);
    int_pin[0] = 1'b1;
    repeat (26) cycle();
    expect_lit("gate_run", 0, 8'h02);
    wr(2, 8'h00);
    int_pin[0] = 1'b0;

    // Mode 2 one-shot.
    wr(3, 8'h00); wr(0, 8'hFF); wr(1, 8'hFF); wr(2, 8'h12);
    repeat (12) cycle();
    expect_lit("os_tl", 0, 8'h00);
    expect_lit("os_ctrl", 2, 8'h02);
    expect_bit("os_tf", tf[0], m_tf[0], 1'b1);
    expect_bit("os_tr", tr[0], m_tr[0], 1'b0);
    repeat (100) cycle();
    expect_lit("os_hold_tl", 0, 8'h00);
    expect_lit("os_hold_th", 1, 8'h00);

    // Collisions: tf_clr against overflow, TL write against tick, reset mid-count.
    wr(3, 8'h00); wr(0, 8'hFF); wr(1, 8'hFF); wr(2, 8'h10);
    wait_tick_next();
    tf_clr = 3'b001;
    cycle();
    tf_clr = '0;
    expect_bit("clr_vs_ovf", tf[0], m_tf[0], 1'b1);
    expect_lit("clr_vs_ovf_tl", 0, 8'h00);
    wait_tick_next();
    wr(0, 8'h5A);
    expect_lit("wr_vs_tick", 0, 8'h5A);
    repeat (5) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) expect_lit($sformatf("rst_mid%0d", a), a, 8'h00);
    expect_bit("rst_mid_tr", tr[0], m_tr[0], 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 399) == 0);
      reg_we = ($urandom_range(0, 5) == 0);
      reg_addr = AW'($urandom);
      case ($urandom_range(0, 3))
        0:       reg_wdata = 8'hFF;
        1:       reg_wdata = 8'hFE;
        default: reg_wdata = 8'($urandom);
      endcase
      if (reg_addr[1:0] == 2'd2 && $urandom_range(0, 1) == 1) reg_wdata[4] = 1'b1;
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 3) == 0) t_pin[i] = ~t_pin[i];
        if ($urandom_range(0, 15) == 0) int_pin[i] = ~int_pin[i];
        tf_clr[i] = ($urandom_range(0, 7) == 0);
      end
      cycle();
    end
    reset = 1'b0; reg_we = 1'b0; tf_clr = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter_bank.md
Name: timer_counter_bank

Overview:
Parametrised bank of 8051-style timer/counters for the MCU51 core, generalising Timer0/Timer1 to NUM_TIMERS channels and a configurable count width. Each channel counts either machine-cycle ticks from a shared prescaler or falling edges on an external pin. Counting can be gated by an external level input. Runs in free-running, 8-bit auto-reload or one-shot mode. Sits on the SFR side of the core; the CPU reads and writes it through a byte-wide register port, and the control unit samples the overflow flags as interrupt requests.

Parameters:
NUM_TIMERS, 2, number of independent channels (1..8)
WIDTH, 16, count width per channel (9..16); TL holds bits 7:0, TH holds bits WIDTH-1:8
PRESCALE, 12, clk cycles per machine-cycle tick (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
t_pin  in  NUM_TIMERS  external count inputs, asynchronous
int_pin  in  NUM_TIMERS  external gate inputs, asynchronous
reg_we  in  1  register write strobe
reg_addr  in  clog2(NUM_TIMERS)+2  {channel, field}; field 0=TL, 1=TH, 2=CTRL, 3=FLAG
reg_wdata  in  8  write data
reg_rdata  out  8  read data, combinational from reg_addr
tf_clr  in  NUM_TIMERS  interrupt-acknowledge clear of tf
tf  out  NUM_TIMERS  overflow flags
tr  out  NUM_TIMERS  run bits, mirrored from CTRL

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all counts 0, CTRL 0, tf 0, tr 0, prescaler 0, synchronisers 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is high for one clk in the cycle where the prescaler is at PRESCALE-1.
- CTRL layout: bit1:0 = mode, bit2 = ct (0 timer, 1 counter), bit3 = gate, bit4 = tr. Bits 7:5 read 0.
- FLAG layout: bit0 = tf. Other bits read 0.
- Run condition: tr & (~gate | int_sync).
- Increment event:
  - Timer mode: run & tick.
  - Counter mode: run & falling edge of t_pin.
  - t_pin and int_pin each pass through a 2-FF synchroniser. The edge is detected against a third register.
  - Latency: the count updates on the 3rd rising edge after t_pin is first sampled low.
  - Pulse high and low phases must each be >=2 clk wide; narrower pulses may be missed.
- Modes:
  - 0 free-run: WIDTH-bit count. All-ones +1 wraps to 0 and sets tf.
  - 1 auto-reload: only TL counts. TL=FF +1 loads TL<=TH and sets tf. TH is unchanged.
  - 2 one-shot: as mode 0, but overflow also clears tr. The count holds 0 until software sets tr.
  - 3 hold: count frozen regardless of tr. tf is unaffected.
- tf priority:
  - An overflow set wins over tf_clr in the same cycle.
  - A FLAG write wins over both.
- Register writes:
  - A TL, TH or CTRL write in the same cycle as an increment event: the written value is stored and that channel's increment is dropped.
  - A TH write stores bits WIDTH-9:0; upper bits are ignored and read 0.
- Reads: reg_rdata reflects current register state with no read side effects.
- Channel isolation: a channel index >= NUM_TIMERS reads 0 and ignores writes.
- reset mid-count: all state returns to reset values on that edge, with no overflow and no tf.

Decomposition:
- Package timer_pkg holds:
  - mode encodings (MODE_FREE, MODE_RELOAD, MODE_ONESHOT, MODE_HOLD);
  - field addresses (F_TL, F_TH, F_CTRL, F_FLAG);
  - CTRL bit positions.
- Sub-module timer_channel: one counter with its synchronisers, edge detect, mode logic and tf. It is instantiated NUM_TIMERS times by generate.
- Top level holds the prescaler, address decode and read mux.

Test Plan:
- Mode 0, timer, PRESCALE=12, WIDTH=16, ch0 TL=FE TH=FF, tr=1 → count FFFF after 12 clk, 0000 after 24 clk, tf[0]=1, tf[1]=0.
- Mode 1, ch1 TH=FC TL=FC, tr=1 → after 4 ticks TL=FC, TH=FC, tf[1]=1; tf_clr[1] → tf[1]=0 next cycle.
- Counter mode, ch1: 3 falling edges on t_pin[1], 4-clk phases → TL=03 three clk after the last fall; ch0 stays 0.
- Gate=1, tr=1, int_pin[0]=0 for 50 clk → count unchanged; int_pin high → counting resumes, first increment on the first tick after synchroniser delay.
- Mode 2, TL=FF TH=FF → overflow: tf=1, tr=0, count holds 0000 for 100 clk.
- Collisions:
  - tf_clr on the overflow cycle → tf=1.
  - TL write of 5A on a tick cycle → TL=5A.
  - reset asserted mid-count → all reads 0 next cycle.
